// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that funnels NREQ valid/ready requesters into one async FIFO write port.
// Each grant accepts up to MAX_BURST beats and is followed by one IDLE arbitration cycle.
module fifo_wr_arbiter #(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*DSIZE-1:0] i_req_data,
    output logic [NREQ-1:0]       o_req_ready,
    output logic [NREQ-1:0]       o_grant,
    output logic                  o_wr,
    output logic [DSIZE-1:0]      o_wdata,
    input  logic                  i_wfull,
    output logic                  o_busy
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q;
    logic [NREQ-1:0] grant_q;
    logic [IW-1:0]   g_q;
    logic [IW-1:0]   p_q;
    logic [3:0]      bc_q;

    logic [IW-1:0]   sel_d;
    logic [NREQ-1:0] grant_d;
    logic [IW-1:0]   p_d;
    logic [3:0]      bc_d;
    logic            g_valid;
    logic            beat;
    logic            last_beat;
    logic [DSIZE-1:0] req_data_a [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_slice
        assign req_data_a[k] = i_req_data[k*DSIZE +: DSIZE];
    end

    // First valid requester at or above start, wrapping past NREQ-1 back to 0.
    function automatic logic [IW-1:0] first_from(input logic [NREQ-1:0] v,
                                                 input logic [IW-1:0]   start);
        logic [IW-1:0] r;
        logic          hit;
        int            idx;
        r   = start;
        hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(start) + i) % NREQ;
            if (!hit && v[idx[IW-1:0]]) begin
                r   = idx[IW-1:0];
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        sel_d          = first_from(i_req_valid, p_q);
        grant_d        = '0;
        grant_d[sel_d] = 1'b1;
    end

    assign p_d       = (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;
    assign bc_d      = bc_q + 4'd1;
    assign g_valid   = i_req_valid[g_q];
    assign beat      = g_valid && o_req_ready[g_q];
    assign last_beat = beat && (bc_d == 4'(MAX_BURST));

    // Ready is combinational so a full FIFO or reset blocks the transfer in the same cycle.
    always_comb begin
        o_req_ready = '0;
        if (state_q == GRANT && !i_wfull && i_rst_n) begin
            o_req_ready = grant_q;
        end
    end

    assign o_wr    = beat;
    assign o_wdata = (state_q == GRANT) ? req_data_a[g_q] : '0;
    assign o_grant = grant_q;
    assign o_busy  = (state_q == GRANT);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            g_q     <= '0;
            p_q     <= '0;
            bc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|i_req_valid) begin
                        g_q     <= sel_d;
                        grant_q <= grant_d;
                        bc_q    <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    // A dropped valid releases even while the FIFO is full.
                    if (!g_valid || last_beat) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        p_q     <= p_d;
                        if (beat) begin
                            bc_q <= bc_d;
                        end
                    end else if (beat) begin
                        bc_q <= bc_d;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: queue-driven requesters, an emulated FIFO/reader,
// and a cycle-level reference model compared against every output each cycle.
module tb_fifo_wr_arbiter;

    localparam int DSIZE     = 8;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 4;

    logic                  i_clk       = 1'b0;
    logic                  i_rst_n     = 1'b0;
    logic [NREQ-1:0]       i_req_valid = '0;
    logic [NREQ*DSIZE-1:0] i_req_data  = '0;
    logic                  i_wfull     = 1'b0;
    logic [NREQ-1:0]       o_req_ready;
    logic [NREQ-1:0]       o_grant;
    logic                  o_wr;
    logic [DSIZE-1:0]      o_wdata;
    logic                  o_busy;

    always #5 i_clk = ~i_clk;

    fifo_wr_arbiter #(
        .DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req_valid(i_req_valid),
        .i_req_data (i_req_data),
        .o_req_ready(o_req_ready),
        .o_grant    (o_grant),
        .o_wr       (o_wr),
        .o_wdata    (o_wdata),
        .i_wfull    (i_wfull),
        .o_busy     (o_busy)
    );

    int nchecks = 0;
    int nerrs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester queues, FIFO emulation and reader.
    logic [DSIZE-1:0] q [NREQ][$];
    logic [NREQ-1:0]  en        = '0;
    logic             man_wfull = 1'b0;
    logic             fifo_mode = 1'b0;
    logic [DSIZE-1:0] fifo [$];
    int               rd_seq [NREQ] = '{default: 0};
    int               rd_total = 0;
    int               rd_tick  = 0;

    always begin : driver
        logic [NREQ-1:0]  hs;
        logic             wr_s;
        logic [DSIZE-1:0] wd_s;
        logic [DSIZE-1:0] d;
        @(negedge i_clk);
        for (int k = 0; k < NREQ; k++) begin
            i_req_valid[k] = en[k] && (q[k].size() > 0);
            i_req_data[k*DSIZE +: DSIZE] = (q[k].size() > 0) ? q[k][0] : '0;
        end
        i_wfull = fifo_mode ? (fifo.size() >= DEPTH) : man_wfull;
        #4;
        hs   = i_req_valid & o_req_ready;
        wr_s = o_wr;
        wd_s = o_wdata;
        @(posedge i_clk);
        for (int k = 0; k < NREQ; k++) begin
            if (hs[k]) void'(q[k].pop_front());
        end
        if (fifo_mode) begin
            if (wr_s) fifo.push_back(wd_s);
            rd_tick++;
            if (rd_tick % 3 == 0 && fifo.size() > 0) begin
                d = fifo.pop_front();
                chk("rd_order", 32'(d[5:0]), 32'(rd_seq[d[7:6]]));
                rd_seq[d[7:6]]++;
                rd_total++;
            end
        end
    end

    // Reference model: owner index (-1 when idle), rotate pointer, beats in current grant.
    int               m_own   = -1;
    int               m_ptr   = 0;
    int               m_beats = 0;
    int               cyc     = 0;
    int               wr_cyc [$];
    logic [DSIZE-1:0] wr_dat [$];
    int               gnt_req [$];
    int               gb [$];
    logic [NREQ-1:0]  prev_g = '0;

    always begin : compare
        logic [NREQ-1:0]  e_grant;
        logic [NREQ-1:0]  e_ready;
        logic             e_wr;
        logic [DSIZE-1:0] e_wdata;
        int               n_own, n_ptr, n_beats, o, gi;
        @(negedge i_clk);
        #4;
        o       = (m_own < 0) ? 0 : m_own;
        e_grant = '0;
        if (m_own >= 0) e_grant[o] = 1'b1;
        e_ready = (m_own >= 0 && !i_wfull && i_rst_n) ? e_grant : '0;
        e_wr    = (m_own >= 0) && i_req_valid[o] && e_ready[o];
        e_wdata = (m_own >= 0) ? i_req_data[o*DSIZE +: DSIZE] : '0;
        chk("grant",   32'(o_grant),     32'(e_grant));
        chk("ready",   32'(o_req_ready), 32'(e_ready));
        chk("busy",    32'(o_busy),      32'(m_own >= 0));
        chk("wr",      32'(o_wr),        32'(e_wr));
        chk("wdata",   32'(o_wdata),     32'(e_wdata));
        chk("onehot0", 32'($onehot0(o_grant)), 32'd1);

        gi = 0;
        for (int k = 0; k < NREQ; k++) if (o_grant[k]) gi = k;
        if (o_grant != '0 && prev_g == '0) begin
            gnt_req.push_back(gi);
            gb.push_back(0);
        end
        if (o_wr) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(o_wdata);
            if (gb.size() > 0) gb[gb.size()-1]++;
        end
        prev_g = o_grant;

        n_own = m_own; n_ptr = m_ptr; n_beats = m_beats;
        if (!i_rst_n) begin
            n_own = -1; n_ptr = 0; n_beats = 0;
        end else if (m_own < 0) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (i_req_valid[(m_ptr + i) % NREQ]) n_own = (m_ptr + i) % NREQ;
            end
            n_beats = 0;
        end else if (!i_req_valid[m_own]) begin
            n_own = -1; n_ptr = (m_own + 1) % NREQ;
        end else if (e_wr) begin
            n_beats = m_beats + 1;
            if (n_beats == MAX_BURST) begin
                n_own = -1; n_ptr = (m_own + 1) % NREQ;
            end
        end
        @(posedge i_clk);
        m_own = n_own; m_ptr = n_ptr; m_beats = n_beats;
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    function automatic bit pending();
        for (int k = 0; k < NREQ; k++) if (q[k].size() > 0) return 1'b1;
        return o_busy;
    endfunction

    task automatic timeout(input string name);
        nchecks++;
        nerrs++;
        $display("FAIL %s_timeout: wait expired, got no progress, expected completion at %0t", name, $time);
    endtask

    task automatic drain(input int budget, input string name);
        int t = 0;
        while (t < budget && pending()) begin
            step(1);
            t++;
        end
        if (pending()) timeout(name);
    endtask

    initial begin
        int bw, bg, bg2, c0, t;
        step(3);
        i_rst_n = 1'b1;
        step(1);
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_ready", 32'(o_req_ready), 32'd0);

        // Single requester, six beats: 4-beat burst, one idle cycle, 2-beat burst.
        bw = wr_dat.size(); bg = gnt_req.size(); c0 = cyc;
        for (int i = 0; i < 6; i++) q[0].push_back(8'hA0 + 8'(i));
        en = 4'b0001;
        drain(300, "s1");
        chk("s1_nwr", 32'(wr_dat.size() - bw), 32'd6);
        for (int i = 0; i < 6; i++) chk("s1_data", 32'(wr_dat[bw+i]), 32'hA0 + 32'(i));
        chk("s1_first_wr", 32'(wr_cyc[bw] - c0), 32'd1);
        chk("s1_b2b",      32'(wr_cyc[bw+3] - wr_cyc[bw]), 32'd3);
        chk("s1_gap",      32'(wr_cyc[bw+4] - wr_cyc[bw+3]), 32'd2);
        chk("s1_ngrants",  32'(gnt_req.size() - bg), 32'd2);
        chk("s1_g0", 32'(gnt_req[bg]), 32'd0);
        chk("s1_g1", 32'(gnt_req[bg+1]), 32'd0);
        chk("s1_burst0", 32'(gb[bg]), 32'd4);
        chk("s1_burst1", 32'(gb[bg+1]), 32'd2);

        // All four valid from a fresh reset: strict rotation, full bursts.
        i_rst_n = 1'b0;
        step(1);
        i_rst_n = 1'b1;
        bg = gnt_req.size();
        for (int k = 0; k < NREQ; k++)
            for (int i = 0; i < 8; i++) q[k].push_back(8'(k * 16 + i));
        en = 4'b1111;
        drain(500, "s2");
        chk("s2_ngrants", 32'(gnt_req.size() - bg), 32'd8);
        chk("s2_o0", 32'(gnt_req[bg]),   32'd0);
        chk("s2_o1", 32'(gnt_req[bg+1]), 32'd1);
        chk("s2_o2", 32'(gnt_req[bg+2]), 32'd2);
        chk("s2_o3", 32'(gnt_req[bg+3]), 32'd3);
        chk("s2_o4", 32'(gnt_req[bg+4]), 32'd0);
        for (int i = 0; i < 5; i++) chk("s2_beats", 32'(gb[bg+i]), 32'd4);

        // FIFO full for three cycles in the middle of req2's burst.
        bw = wr_dat.size(); bg = gnt_req.size();
        for (int i = 0; i < 4; i++) q[2].push_back(8'hC0 + 8'(i));
        en = 4'b0100;
        t = 0;
        while (wr_dat.size() - bw < 2 && t < 100) begin step(1); t++; end
        if (wr_dat.size() - bw < 2) timeout("s3_beats");
        man_wfull = 1'b1;
        step(3);
        man_wfull = 1'b0;
        drain(100, "s3");
        chk("s3_nwr",     32'(wr_dat.size() - bw), 32'd4);
        chk("s3_ngrants", 32'(gnt_req.size() - bg), 32'd1);
        chk("s3_owner",   32'(gnt_req[bg]), 32'd2);
        chk("s3_burst",   32'(gb[bg]), 32'd4);
        chk("s3_stall",   32'(wr_cyc[bw+2] - wr_cyc[bw+1]), 32'd4);
        chk("s3_last",    32'(wr_dat[bw+3]), 32'hC3);

        // req1 drops valid after two beats while req3 and req0 wait: pointer moves to 2.
        bw = wr_dat.size(); bg = gnt_req.size();
        for (int i = 0; i < 4; i++) q[1].push_back(8'hB0 + 8'(i));
        en = 4'b0010;
        t = 0;
        while (o_grant != 4'b0010 && t < 50) begin step(1); t++; end
        if (o_grant != 4'b0010) timeout("s4_grant");
        q[3].push_back(8'hD0);
        q[3].push_back(8'hD1);
        q[0].push_back(8'hE0);
        en = 4'b1011;
        t = 0;
        while (wr_dat.size() - bw < 2 && t < 50) begin step(1); t++; end
        if (wr_dat.size() - bw < 2) timeout("s4_beats");
        en = 4'b1001;
        t = 0;
        while (gnt_req.size() - bg < 3 && t < 100) begin step(1); t++; end
        if (gnt_req.size() - bg < 3) timeout("s4_regrant");
        chk("s4_first", 32'(gnt_req[bg]),   32'd1);
        chk("s4_beats", 32'(gb[bg]),        32'd2);
        chk("s4_next",  32'(gnt_req[bg+1]), 32'd3);
        chk("s4_then",  32'(gnt_req[bg+2]), 32'd0);
        en = 4'b1111;
        drain(200, "s4");

        // Leave the pointer at 2, then reset during beat 2 of req2's burst.
        q[1].push_back(8'h5A);
        en = 4'b0010;
        drain(50, "s5_pre");
        bw = wr_dat.size();
        for (int i = 0; i < 4; i++) q[2].push_back(8'h60 + 8'(i));
        en = 4'b0100;
        t = 0;
        while (wr_dat.size() - bw < 1 && t < 50) begin step(1); t++; end
        if (wr_dat.size() - bw < 1) timeout("s5_beat");
        i_rst_n = 1'b0;
        q[0].push_back(8'h70);
        en = 4'b0101;
        step(1);
        chk("s5_busy",  32'(o_busy),  32'd0);
        chk("s5_grant", 32'(o_grant), 32'd0);
        chk("s5_nwr",   32'(wr_dat.size() - bw), 32'd1);
        i_rst_n = 1'b1;
        bg2 = gnt_req.size();
        t = 0;
        while (gnt_req.size() <= bg2 && t < 20) begin step(1); t++; end
        if (gnt_req.size() <= bg2) timeout("s5_regrant");
        chk("s5_winner", 32'(gnt_req[bg2]), 32'd0);
        en = 4'b1111;
        drain(200, "s5");

        // End to end through an emulated 4-deep FIFO with a slow reader: 64 beats.
        fifo_mode = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            rd_seq[k] = 0;
            for (int i = 0; i < 16; i++) q[k].push_back(8'(k * 64 + i));
        end
        rd_total = 0;
        en = 4'b1111;
        drain(3000, "s6");
        t = 0;
        while (fifo.size() > 0 && t < 100) begin step(1); t++; end
        if (fifo.size() > 0) timeout("s6_reader");
        chk("s6_total", 32'(rd_total), 32'd64);
        for (int k = 0; k < NREQ; k++) chk("s6_count", 32'(rd_seq[k]), 32'd16);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The module SHALL have parameter DSIZE, default 8, meaning the data width of each requester and of the FIFO write port.
REQ-002 The module SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-003 The module SHALL have parameter MAX_BURST, default 4, meaning the maximum beats accepted per grant (1..15).
REQ-004 The module SHALL have the port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have the port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have the port i_req_valid, input, NREQ bits: per-requester valid; bit k belongs to requester k.
REQ-007 The module SHALL have the port i_req_data, input, NREQ*DSIZE bits: requester k data in bits [k*DSIZE +: DSIZE].
REQ-008 The module SHALL have the port o_req_ready, output, NREQ bits: per-requester ready; a beat transfers when valid and ready are both 1.
REQ-009 The module SHALL have the port o_grant, output, NREQ bits: registered one-hot grant, all-zero when no grant is held.
REQ-010 The module SHALL have the port o_wr, output, 1 bit: the FIFO write strobe, driving i_wr of the async FIFO write port.
REQ-011 The module SHALL have the port o_wdata, output, DSIZE bits: the FIFO write data, driving i_wdata.
REQ-012 The module SHALL have the port i_wfull, input, 1 bit: the FIFO full flag, taken from o_wfull of the write domain.
REQ-013 The module SHALL have the port o_busy, output, 1 bit: 1 while the FSM is in GRANT.

Function
REQ-014 The FSM SHALL have two states, IDLE and GRANT, with registered grant index g, rotate pointer p (log2 NREQ bits) and burst counter bc (4 bits).
REQ-015 In IDLE with any i_req_valid bit set, the arbiter SHALL select the first valid requester searching upward from p with wrap-around, load o_grant one-hot for it, clear bc and enter GRANT at the next edge.
REQ-016 In IDLE with no valid request, the FSM SHALL remain in IDLE, and o_grant SHALL be 0.
REQ-017 o_req_ready[k] SHALL be combinational, equal to (state==GRANT && o_grant[k] && !i_wfull && i_rst_n); all other ready bits SHALL be 0.
REQ-018 o_wr SHALL equal i_req_valid[g] && o_req_ready[g] in the same cycle, with zero latency, so a write never occurs while i_wfull is 1.
REQ-019 o_wdata SHALL equal the i_req_data slice of requester g while in GRANT, and SHALL be 0 otherwise.
REQ-020 Each accepted beat SHALL increment bc by 1.
REQ-021 The grant SHALL be released (GRANT->IDLE, o_grant cleared, p<=g+1 mod NREQ) on the edge where the accepted beat makes bc reach MAX_BURST.
REQ-022 The grant SHALL also be released, by the same rule, on an edge where i_req_valid[g] is 0.
REQ-023 While i_wfull is 1, the grant SHALL be held, bc SHALL be unchanged, and no beat SHALL transfer; a low valid still releases the grant per REQ-022.
REQ-024 Every release SHALL be followed by exactly one IDLE arbitration cycle, so the minimum spacing between grants is 1 cycle.
REQ-025 Requesters SHALL hold valid and data stable until the beat is accepted; the module does not buffer data.
REQ-026 Valid bits that change during GRANT for non-granted requesters SHALL have no effect until the next IDLE cycle.

Reset
REQ-027 With i_rst_n low at a rising edge, the module SHALL set the state to IDLE, o_grant=0, p=0 and bc=0.
REQ-028 While i_rst_n is low, o_wr and o_req_ready SHALL be forced to 0 combinationally, including mid-burst, and o_wdata and o_busy SHALL be 0 after the edge.
REQ-029 After reset release, requester 0 SHALL have the highest priority for the first arbitration.

Verification
REQ-030 Scenario, single requester: req0 valid with data 0xA0..0xA5, FIFO never full -> grant0 at cycle 1; writes 0xA0..0xA3 on consecutive cycles; 1 IDLE cycle; regrant to 0; writes 0xA4, 0xA5.
REQ-031 Scenario, all four valid continuously -> grant order 0,1,2,3,0 with 4 beats each and a 1-cycle IDLE gap; o_grant is always one-hot or zero.
REQ-032 Scenario, i_wfull asserted for 3 cycles mid-burst of req2 -> o_wr=0 and ready=0 for those 3 cycles; the burst resumes with bc preserved; the total beat count is still 4.
REQ-033 Scenario, req1 drops valid after 2 beats while req3 is waiting -> release on that edge, p=2, and the next grant goes to req3.
REQ-034 Scenario, i_rst_n low during beat 2 of a burst -> o_wr=0 in that cycle and state IDLE; after release, req0 wins even if p was nonzero.
REQ-035 Scenario, end-to-end with the async FIFO and a reader -> the per-requester order is preserved, there are no writes while full, and the scoreboard matches all 64 beats.
